bcd_timer_ctrl: RTL
===================

// Module: bcd_timer_ctrl
// PURPOSE
//  Run-control sequencer for a chain of cascaded up/down BCD digit counters.
//  Supports start, stop/pause, clear and parallel load of the chain.
//  A prescaler turns clk into count steps. Each step advances the chain by
//  one in the latched direction. The block flags terminal count
//  (0…0 counting down, 9…9 counting up).
//  Sits between the panel/button logic and the 7-segment display path.
// PARAMETERS
//  DIGITS    4   number of BCD digits in the chain (1..8)
//  PRESCALE  50  clk cycles per count step (>=2)
//  PW        6   prescaler width; must satisfy 2**PW >= PRESCALE
// PORTS
//  clk       in   1          system clock; all state updates on posedge
//  reset     in   1          synchronous, active-high reset
//  start     in   1          1-cycle pulse: begin or resume counting
//  stop      in   1          1-cycle pulse: pause counting
//  clear     in   1          1-cycle pulse: zero the chain, return to IDLE
//  load      in   1          1-cycle pulse: parallel-load load_val
//  load_val  in   4*DIGITS   BCD value to load; digit 0 = LSBs
//  dir       in   1          0 = count up, 1 = count down; sampled on start
//  count     out  4*DIGITS   current BCD chain value
//  running   out  1          high while state == RUN
//  done      out  1          1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset: state=IDLE, count=0, prescaler=0, dir_q=0, running=0, done=0.
//  States: IDLE, RUN, PAUSE, DONE. running and done are registered.
//  Command priority in the same cycle: clear > load > stop > start.
//  clear:
//   - any state -> IDLE; count=0, prescaler=0 on the next edge.
//  load:
//   - Accepted in IDLE, PAUSE or DONE. Next state is IDLE and the prescaler
//     is set to 0.
//   - count <= load_val. Any digit >9 is clamped to 9.
//   - Ignored in RUN.
//  start:
//   - IDLE -> RUN: dir_q <= dir, prescaler <= 0.
//   - IDLE with count already terminal for dir: go straight to DONE instead.
//   - PAUSE -> RUN: prescaler resumes from its held value; dir_q unchanged.
//   - Ignored in RUN and DONE.
//  stop: RUN -> PAUSE; prescaler and count hold. Ignored elsewhere.
//  Prescaler (RUN only):
//   - Counts 0..PRESCALE-1 and wraps.
//   - step = (state==RUN) && (prescaler==PRESCALE-1).
//   - With no pause, the first step lands PRESCALE edges after the edge
//     that accepted start. Steps then repeat every PRESCALE cycles.
//  Step arithmetic (ripple enable):
//   - Digit 0 is enabled on step.
//   - Digit i>0 is enabled when step is high and every lower digit is 9
//     (up) or 0 (down).
//   - An enabled digit wraps 9->0 (up) or 0->9 (down).
//   - A dir change during RUN has no effect (dir_q is used).
//  Terminal:
//   - If a step makes count terminal (all 9 up / all 0 down), the same edge
//     sets state=DONE, running=0 and done=1 for exactly one cycle.
//   - The chain never wraps past terminal.
//   - DONE holds count. Leave DONE by load or clear.
//  Simultaneous events:
//   - stop in the step cycle: the step still applies and state goes PAUSE.
//     If that step reaches terminal, DONE wins.
//   - clear in the step cycle: clear wins; no step, no done.
//  reset mid-run: same as power-on reset on the next edge; no done pulse.
// STRUCTURE
//  Package bcd_timer_pkg:
//   - state encoding localparams (S_IDLE, S_RUN, S_PAUSE, S_DONE)
//   - BCD_MAX=4'h9, BCD_MIN=4'h0, DIR_UP=1'b0, DIR_DN=1'b1
//  Sub-module bcd_digit (one per digit, generate loop):
//   - ports: clk, reset, en, dir, ld, ld_val[3:0], q[3:0]
//   - sync reset; 9/0 wrap. Clamping to 9 happens in bcd_digit.
//  Top level holds the FSM, the prescaler, the ripple-enable and
//  terminal-detect logic, and the output registers.
// TESTING (DIGITS=2, PRESCALE=4)
//  1. Reset held 3 cycles, then released -> count=8'h00, running=0, done=0.
//  2. load 8'h12, then start with dir=1 ->
//     count=11 at 4 edges after start, 10 at 8 edges, 09 at 12 edges;
//     later reaches 00; done high exactly 1 cycle; state=DONE.
//  3. dir=0 from 00 -> 09 then 10 (carry into digit 1);
//     load 98 then start -> 99 gives done; count holds at 99.
//  4. stop after 2 prescaler cycles, wait 10 cycles, start ->
//     next step comes 2 cycles after resume; count unchanged while paused.
//  5. load 8'hA5 -> count=95. load asserted while running -> ignored.
//     clear together with load -> count=00, IDLE.
//  6. clear or reset asserted in a step cycle -> count=00, no done pulse.
//     start in DONE -> no change.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared state encoding and BCD constants for the timer chain
package bcd_timer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'h9;
  localparam logic [3:0] BCD_MIN = 4'h0;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down BCD digit with clamped parallel load
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= BCD_MIN;
    else if (ld) q <= (ld_val > BCD_MAX) ? BCD_MAX : ld_val;
    else if (en) q <= (dir == DIR_DN) ? ((q == BCD_MIN) ? BCD_MAX : q - 4'd1)
                                      : ((q == BCD_MAX) ? BCD_MIN : q + 4'd1);
endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: run/pause/clear/load sequencer with prescaler driving a cascaded BCD digit chain
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50,
  parameter int PW       = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic dir_q, step, load_ok, pre_term, term_start;
  logic [DIGITS-1:0] at_max, at_min, at_tgt, en;
  assign load_ok    = load && !clear && state != S_RUN;
  assign step       = state == S_RUN && presc == P_LAST && !clear;
  assign at_tgt     = (dir_q == DIR_DN) ? at_min : at_max;
  assign term_start = &((dir == DIR_DN) ? at_min : at_max);
  // Only digit 0 moves on the step that lands on terminal: it must sit one away while all others are at target
  assign pre_term   = count[3:0] == ((dir_q == DIR_DN) ? 4'd1 : 4'd8) && &(at_tgt | DIGITS'(1));
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam logic [DIGITS-1:0] LOW = DIGITS'((64'd1 << i) - 64'd1);
    assign at_max[i] = count[4*i+:4] == BCD_MAX;
    assign at_min[i] = count[4*i+:4] == BCD_MIN;
    assign en[i]     = step && &(at_tgt | ~LOW);
    bcd_digit u_dig (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .dir    (dir_q),
      .ld     (clear || load_ok),
      .ld_val (clear ? BCD_MIN : load_val[4*i+:4]),
      .q      (count[4*i+:4])
    );
  end
  always_comb begin
    state_n = state;
    presc_n = presc;
    if (clear || load_ok) begin
      state_n = S_IDLE;
      presc_n = '0;
    end else case (state)
      S_IDLE: if (start) begin
        state_n = term_start ? S_DONE : S_RUN;
        presc_n = '0;
      end
      S_RUN: begin
        state_n = (step && pre_term) ? S_DONE : stop ? S_PAUSE : S_RUN;
        presc_n = stop ? presc : step ? '0 : presc + PW'(1);
      end
      S_PAUSE: if (start) state_n = S_RUN;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state   <= S_IDLE;
      presc   <= '0;
      dir_q   <= DIR_UP;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      running <= state_n == S_RUN;
      done    <= state_n == S_DONE && state != S_DONE;
      if (state == S_IDLE && start && !clear && !load) dir_q <= dir;
    end
endmodule
